sram_like_slave_adapter: RTL and testbench

//  Sits downstream of the CPU's sram-like inst or data port. Turns each sram-like request into one synchronous-SRAM access.

---
 rtl/sram_like_pkg.sv | 28 ++
 rtl/sram_like_slave_adapter_if.sv | 29 ++
 rtl/sram_like_resp_fifo.sv | 90 +++++++++
 rtl/sram_like_slave_adapter.sv | 64 ++++++
 tb/tb_sram_like_slave_adapter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the sram-like slave adapter.
// Holds the size encodings, the byte-mask helper and the response queue entry layout.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
        logic [4:0]  timer;
        logic        captured;
    } entry_t;

    // Reserved size 3 yields no enables; the access is still answered.
    function automatic logic [3:0] size_to_wen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] wen;
        case (size)
            SIZE_BYTE: wen = 4'b0001 << addr_lo;
            SIZE_HALF: wen = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: wen = 4'b1111;
            default:   wen = 4'b0000;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/sram_like_slave_adapter_if.sv
// Bundle of the sram-like request/response signals and the synchronous-SRAM side.
// The slave modport is the adapter's view; master is the CPU + SRAM side.
interface sram_like_slave_adapter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  req, wr, size, addr, wdata, sram_rdata,
        output rdata, addr_ok, data_ok, sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output req, wr, size, addr, wdata, sram_rdata,
        input  rdata, addr_ok, data_ok, sram_en, sram_wen, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: DEPTH-entry circular buffer with per-entry capture state and timers.
// The head retires (head_ready) once its SRAM data is captured and its timer has reached zero.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        push_wr,
    input  logic [4:0]  push_timer,
    input  logic [31:0] sram_rdata,
    output logic        full,
    output logic        head_ready,
    output logic [31:0] head_rdata
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          view  [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cap_ptr_q, cap_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            cap_pend_q, cap_pend_d;
    logic            pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // The entry pushed last cycle sees its SRAM data live this cycle, so it counts as captured.
        for (int i = 0; i < DEPTH; i++) begin
            view[i] = mem_q[i];
            if (cap_pend_q && cap_ptr_q == PtrW'(i)) begin
                view[i].captured = 1'b1;
                view[i].rdata    = mem_q[i].wr ? 32'h0 : sram_rdata;
            end
        end

        full       = (count_q == CntW'(DEPTH));
        head_ready = (count_q != '0) && view[rptr_q].captured && (view[rptr_q].timer == 5'd0);
        head_rdata = view[rptr_q].rdata;
        pop        = head_ready;

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = view[i];
            if (view[i].captured && view[i].timer != 5'd0) begin
                mem_d[i].timer = view[i].timer - 5'd1;
            end
        end

        wptr_d     = wptr_q;
        rptr_d     = pop ? next_ptr(rptr_q) : rptr_q;
        cap_pend_d = push;
        cap_ptr_d  = wptr_q;
        if (push) begin
            mem_d[wptr_q] = '{wr: push_wr, rdata: 32'h0, timer: push_timer, captured: 1'b0};
            wptr_d        = next_ptr(wptr_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            wptr_q     <= '0;
            rptr_q     <= '0;
            cap_ptr_q  <= '0;
            count_q    <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cap_ptr_q  <= cap_ptr_d;
            count_q    <= count_d;
            cap_pend_q <= cap_pend_d;
        end
    end

endmodule

// File: rtl/sram_like_slave_adapter.sv
// Sram-like slave to synchronous-SRAM adapter: one SRAM access per request, in-order data_ok.
// Optional SRAM_LIKE_RAND_DELAY_EN adds LFSR-driven response jitter and accept throttling.
module sram_like_slave_adapter
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    sram_like_slave_adapter_if.slave    bus
);

    logic        full;
    logic        accept;
    logic        head_ready;
    logic [31:0] head_rdata;
    logic [4:0]  push_timer;
    logic        lfsr_block;

`ifdef SRAM_LIKE_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'h5A;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign push_timer = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
    assign lfsr_block = lfsr_q[2];
`else
    assign push_timer = 5'(LATENCY);
    assign lfsr_block = 1'b0;
`endif

    // addr_ok depends only on registered state, so a retiring head never frees a slot same-cycle.
    assign bus.addr_ok    = ~full & ~reset & ~lfsr_block;
    assign accept         = bus.req & bus.addr_ok;
    assign bus.sram_en    = accept;
    assign bus.sram_wen   = (accept && bus.wr) ? size_to_wen(bus.size, bus.addr[1:0]) : 4'b0000;
    assign bus.sram_addr  = {bus.addr[31:2], 2'b00};
    assign bus.sram_wdata = bus.wdata;
    assign bus.data_ok    = head_ready & ~reset;
    assign bus.rdata      = bus.data_ok ? head_rdata : 32'h0;

    sram_like_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_wr    (bus.wr),
        .push_timer (push_timer),
        .sram_rdata (bus.sram_rdata),
        .full       (full),
        .head_ready (head_ready),
        .head_rdata (head_rdata)
    );

endmodule

// File: tb/tb_sram_like_slave_adapter.sv
// Bench for sram_like_slave_adapter: two instances (DEPTH=2/LATENCY=1 and DEPTH=4/LATENCY=0)
// checked every cycle against a queue-based model of outstanding requests and their due cycles.
module tb_sram_like_slave_adapter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_like_slave_adapter_if bus0 ();
    sram_like_slave_adapter_if bus1 ();

    sram_like_slave_adapter #(.DEPTH(2), .LATENCY(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    sram_like_slave_adapter #(.DEPTH(4), .LATENCY(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic        req [2];
    logic        wr  [2];
    logic [1:0]  size[2];
    logic [31:0] addr[2];
    logic [31:0] wdat[2];
    logic [31:0] srd [2];
    logic        o_aok[2], o_dok[2], o_en[2];
    logic [3:0]  o_wen[2];
    logic [31:0] o_rdata[2], o_saddr[2], o_swdata[2];

    assign bus0.req = req[0];  assign bus0.wr = wr[0];  assign bus0.size = size[0];
    assign bus0.addr = addr[0]; assign bus0.wdata = wdat[0]; assign bus0.sram_rdata = srd[0];
    assign bus1.req = req[1];  assign bus1.wr = wr[1];  assign bus1.size = size[1];
    assign bus1.addr = addr[1]; assign bus1.wdata = wdat[1]; assign bus1.sram_rdata = srd[1];
    assign o_aok[0] = bus0.addr_ok;   assign o_aok[1] = bus1.addr_ok;
    assign o_dok[0] = bus0.data_ok;   assign o_dok[1] = bus1.data_ok;
    assign o_en[0]  = bus0.sram_en;   assign o_en[1]  = bus1.sram_en;
    assign o_wen[0] = bus0.sram_wen;  assign o_wen[1] = bus1.sram_wen;
    assign o_rdata[0] = bus0.rdata;   assign o_rdata[1] = bus1.rdata;
    assign o_saddr[0] = bus0.sram_addr;   assign o_saddr[1] = bus1.sram_addr;
    assign o_swdata[0] = bus0.sram_wdata; assign o_swdata[1] = bus1.sram_wdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: outstanding requests as a FIFO of (accept cycle, response data).
    int          qacc [2][64];
    logic [31:0] qdata[2][64];
    int          hd[2], tl[2];
    bit          capv[2], capw[2];
    int          capi[2];

    function automatic int dep(int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic logic [3:0] exp_mask(logic [1:0] s, logic [1:0] a);
        case (s)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input bit r, input bit w, input logic [1:0] s,
                           input logic [31:0] a);
        req[k]  = r;
        wr[k]   = w;
        size[k] = s;
        addr[k] = a;
        wdat[k] = $urandom;
    endtask

    task automatic set_all(input bit r, input bit w, input logic [1:0] s, input logic [31:0] a);
        for (int k = 0; k < 2; k++) set_req(k, r, w, s, a);
    endtask

    // One clock cycle: drive SRAM data, check all outputs at negedge, advance the model.
    task automatic tick();
        bit acc[2], dok[2];
        for (int k = 0; k < 2; k++) begin
            srd[k] = $urandom;
            if (capv[k]) qdata[k][capi[k] % 64] = capw[k] ? 32'h0 : srd[k];
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int cnt, due;
            bit eaok, edok;
            cnt  = tl[k] - hd[k];
            due  = qacc[k][hd[k] % 64] + 1 + lat(k);
            eaok = !reset && cnt < dep(k);
            edok = !reset && cnt > 0 && cyc >= due;
`ifdef SRAM_LIKE_RAND_DELAY_EN
            chk("addr_ok_when_full", k, {31'b0, o_aok[k] & ~eaok}, 32'h0);
            acc[k] = req[k] && o_aok[k] && eaok;
            dok[k] = o_dok[k];
            if (o_dok[k]) chk("data_ok_early", k, {31'b0, edok}, 32'h1);
            else          chk("data_ok_late", k, {31'b0, edok && cyc >= due + 3}, 32'h0);
`else
            chk("addr_ok", k, {31'b0, o_aok[k]}, {31'b0, eaok});
            chk("data_ok", k, {31'b0, o_dok[k]}, {31'b0, edok});
            acc[k] = req[k] && eaok;
            dok[k] = edok;
`endif
            chk("sram_en", k, {31'b0, o_en[k]}, {31'b0, acc[k]});
            chk("sram_wen", k, {28'b0, o_wen[k]},
                {28'b0, (acc[k] && wr[k]) ? exp_mask(size[k], addr[k][1:0]) : 4'b0000});
            if (acc[k]) begin
                chk("sram_addr", k, o_saddr[k], {addr[k][31:2], 2'b00});
                chk("sram_wdata", k, o_swdata[k], wdat[k]);
            end
            if (dok[k]) chk("rdata", k, o_rdata[k], qdata[k][hd[k] % 64]);
            if (reset)  chk("rdata_reset", k, o_rdata[k], 32'h0);
        end
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                hd[k] = 0; tl[k] = 0; capv[k] = 1'b0;
            end else begin
                if (dok[k]) hd[k]++;
                capv[k] = acc[k];
                if (acc[k]) begin
                    qacc[k][tl[k] % 64] = cyc;
                    capi[k] = tl[k];
                    capw[k] = wr[k];
                    tl[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hd[k] = 0; tl[k] = 0; capv[k] = 1'b0; capw[k] = 1'b0; capi[k] = 0;
            srd[k] = '0;
        end
        // Reset with a request pending on the bus: nothing may be accepted.
        reset = 1'b1;
        set_all(1'b1, 1'b0, 2'd2, 32'h100);
        tick();
        tick();
        reset = 1'b0;
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        tick();

        // Single word read, then idle for the response.
        set_all(1'b1, 1'b0, 2'd2, 32'h100);
        tick();
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        repeat (3) tick();

        // Byte write to 0x103 -> lane 3.
        set_all(1'b1, 1'b1, 2'd0, 32'h103);
        tick();
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        repeat (3) tick();

        // Request held high: exercises queue full and throughput.
        set_all(1'b1, 1'b0, 2'd2, 32'h200);
        repeat (8) tick();

        // Halfword lanes (addr[0] ignored) and reserved size.
        set_all(1'b1, 1'b1, 2'd1, 32'h102); tick();
        set_all(1'b1, 1'b1, 2'd1, 32'h101); tick();
        set_all(1'b1, 1'b1, 2'd3, 32'h000); tick();
        set_all(1'b1, 1'b1, 2'd0, 32'h001); tick();
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        repeat (4) tick();

        // Reset with requests pending: they must never be answered.
        set_all(1'b1, 1'b0, 2'd2, 32'h300);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        repeat (4) tick();

        // Random traffic.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < 2; k++) begin
                set_req(k, ($urandom_range(3) != 0), $urandom_range(1) == 1,
                        2'($urandom_range(3)), $urandom);
            end
            tick();
        end
        set_all(1'b0, 1'b0, 2'd2, 32'h0);
        repeat (12) tick();

        for (int k = 0; k < 2; k++) chk("drained", k, tl[k] - hd[k], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
